mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 43 ++++
 rtl/mem_ctrl.sv | 149 ++++++++++++++
 tb/tb_mem_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: length codes,
// FSM encodings, bus widths and small byte helpers.
package mem_ctrl_pkg;

  localparam int RamDataBus  = 8;
  localparam int InstAddrBus = 32;

  localparam logic [1:0] LenByte = 2'b00;
  localparam logic [1:0] LenHalf = 2'b01;
  localparam logic [1:0] LenWord = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  // Both 2'b10 and 2'b11 mean a full word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LenByte: return 3'd1;
      LenHalf: return 3'd2;
      LenWord: return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [RamDataBus-1:0] sel_byte(input logic [31:0] w,
                                                     input logic [1:0]  idx);
    case (idx)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates instruction fetches and load/stores onto a byte-wide RAM,
// serialising each access one byte per cycle (MEM has priority over IF).
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [InstAddrBus-1:0] if_addr,
  output logic                   if_done,
  output logic [31:0]            if_data,
  input  logic                   mem_req,
  input  logic                   mem_we,
  input  logic [31:0]            mem_addr,
  input  logic [1:0]             mem_len,
  input  logic [31:0]            mem_wdata,
  output logic                   mem_done,
  output logic [31:0]            mem_rdata,
  output logic [31:0]            ram_a,
  output logic                   ram_wr,
  output logic [RamDataBus-1:0]  ram_dout,
  input  logic [RamDataBus-1:0]  ram_din
);

  state_e                 state_q;
  owner_e                 owner_q;
  logic [2:0]             cnt_q, cnt_d;
  logic [2:0]             n_q;
  logic                   if_done_q, mem_done_q;
  logic [31:0]            if_data_q, mem_rdata_q;
  logic [31:0]            ram_a_q, ram_a_d;
  logic                   ram_wr_q;
  logic [RamDataBus-1:0]  ram_dout_q;
  logic [31:0]            base_q, wdata_q;
  logic [31:0]            asm_q, asm_d;
  logic                   grant;

  // No grant while a done pulse is out, so the requester can drop its req.
  assign grant   = (state_q == ST_IDLE) && !if_done_q && !mem_done_q && (mem_req || if_req);
  assign cnt_d   = cnt_q + 3'd1;
  assign ram_a_d = base_q + {29'd0, cnt_d};

  // ram_din seen at count k belongs to the byte addressed at count k-1.
  always_comb begin
    asm_d = asm_q;
    if (state_q == ST_RD) begin
      case (cnt_q)
        3'd1:    asm_d[7:0]   = ram_din;
        3'd2:    asm_d[15:8]  = ram_din;
        3'd3:    asm_d[23:16] = ram_din;
        3'd4:    asm_d[31:24] = ram_din;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      n_q         <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            cnt_q <= '0;
            if (mem_req) begin
              owner_q    <= OWN_MEM;
              n_q        <= len_bytes(mem_len);
              state_q    <= mem_we ? ST_WR : ST_RD;
              ram_a_q    <= mem_addr;
              ram_wr_q   <= mem_we;
              ram_dout_q <= mem_we ? sel_byte(mem_wdata, 2'd0) : '0;
            end else begin
              owner_q    <= OWN_IF;
              n_q        <= 3'd4;
              state_q    <= ST_RD;
              ram_a_q    <= if_addr;
              ram_wr_q   <= 1'b0;
              ram_dout_q <= '0;
            end
          end
        end
        ST_RD: begin
          if (cnt_q == n_q) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ram_a_q <= '0;
            if (owner_q == OWN_MEM) begin
              mem_done_q  <= 1'b1;
              mem_rdata_q <= asm_d;
            end else begin
              if_done_q <= 1'b1;
              if_data_q <= asm_d;
            end
          end else begin
            cnt_q   <= cnt_d;
            ram_a_q <= (cnt_d == n_q) ? 32'd0 : ram_a_d;
          end
        end
        ST_WR: begin
          if (cnt_q == n_q - 3'd1) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mem_done_q <= 1'b1;
            ram_a_q    <= '0;
            ram_wr_q   <= 1'b0;
            ram_dout_q <= '0;
          end else begin
            cnt_q      <= cnt_d;
            ram_a_q    <= ram_a_d;
            ram_dout_q <= sel_byte(wdata_q, cnt_d[1:0]);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Transaction operands are frozen at grant; later request changes are ignored.
  always_ff @(posedge clk) begin
    if (grant) begin
      base_q  <= mem_req ? mem_addr : if_addr;
      wdata_q <= mem_wdata;
      asm_q   <= '0;
    end else if (state_q == ST_RD) begin
      asm_q <= asm_d;
    end
  end

  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_a     = ram_a_q;
  assign ram_wr    = ram_wr_q;
  assign ram_dout  = ram_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-wide RAM model, reference memory image and
// directed plus randomized fetch/load/store transactions.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_done, mem_req, mem_we, mem_done, ram_wr;
  logic [31:0] if_addr, if_data, mem_addr, mem_wdata, mem_rdata, ram_a;
  logic [1:0]  mem_len;
  logic [7:0]  ram_dout, ram_din;

  logic        pre_en;
  logic [9:0]  pre_a;
  logic [7:0]  pre_d;
  logic [7:0]  ram_m [0:1023];
  logic [7:0]  ref_m [0:1023];
  logic [31:0] exp_if, exp_mem;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_data   (if_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_len   (mem_len),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .ram_a     (ram_a),
    .ram_wr    (ram_wr),
    .ram_dout  (ram_dout),
    .ram_din   (ram_din)
  );

  // RAM: 1 KiB mirrored over the 32-bit space, read data one cycle late.
  always @(posedge clk) begin
    if (pre_en) ram_m[pre_a] <= pre_d;
    else if (ram_wr) ram_m[ram_a[9:0]] <= ram_dout;
    ram_din <= ram_m[ram_a[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, expv);
    end
  endtask

  task automatic preset(input logic [31:0] a, input logic [7:0] d);
    pre_en = 1'b1;
    pre_a  = a[9:0];
    pre_d  = d;
    ref_m[a[9:0]] = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic idle_chk();
    chk("idle_ram_a", ram_a, 32'h0);
    chk("idle_ram_wr", 32'(ram_wr), 32'h0);
    chk("idle_ram_dout", 32'(ram_dout), 32'h0);
    chk("idle_if_done", 32'(if_done), 32'h0);
    chk("idle_mem_done", 32'(mem_done), 32'h0);
  endtask

  // Called at a negedge; raises if_req so that this cycle is request cycle 0.
  task automatic fetch(input logic [31:0] addr);
    logic [31:0] expv, a_i;
    bit          seen;
    expv = '0;
    for (int i = 0; i < 4; i++) begin
      a_i = addr + 32'(i);
      expv[8*i +: 8] = ref_m[a_i[9:0]];
    end
    idle_chk();
    if_req  = 1'b1;
    if_addr = addr;
    seen    = 1'b0;
    for (int cyc = 1; cyc <= 12 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 1) if_addr = $urandom;
      if (cyc <= 4) begin
        a_i = addr + 32'(cyc - 1);
        chk("if_ram_a", ram_a, a_i);
        chk("if_ram_wr", 32'(ram_wr), 32'h0);
      end
      if (if_done) begin
        seen = 1'b1;
        chk("if_latency", cyc, 6);
        chk("if_data", if_data, expv);
        chk("if_mem_rdata_hold", mem_rdata, exp_mem);
        exp_if = expv;
        if_req = 1'b0;
      end
    end
    if (!seen) chk("if_timeout", 32'h0, 32'h1);
  endtask

  task automatic mem_xfer(input logic we, input logic [31:0] addr,
                          input logic [1:0] len, input logic [31:0] wd);
    logic [31:0] expv, a_i;
    int          n;
    bit          seen;
    n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    expv = '0;
    for (int i = 0; i < n; i++) begin
      a_i = addr + 32'(i);
      expv[8*i +: 8] = ref_m[a_i[9:0]];
    end
    idle_chk();
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = addr;
    mem_len   = len;
    mem_wdata = wd;
    seen      = 1'b0;
    for (int cyc = 1; cyc <= 12 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_len   = 2'($urandom);
        mem_we    = ~we;
      end
      if (cyc <= n) begin
        a_i = addr + 32'(cyc - 1);
        chk("mem_ram_a", ram_a, a_i);
        chk("mem_ram_wr", 32'(ram_wr), 32'(we));
        if (we) chk("mem_ram_dout", 32'(ram_dout), 32'(wd[8*(cyc-1) +: 8]));
      end
      if (mem_done) begin
        seen = 1'b1;
        chk("mem_latency", cyc, we ? n + 1 : n + 2);
        chk("mem_if_data_hold", if_data, exp_if);
        chk("mem_if_done_low", 32'(if_done), 32'h0);
        if (we) chk("store_rdata_hold", mem_rdata, exp_mem);
        else begin
          chk("mem_rdata", mem_rdata, expv);
          exp_mem = expv;
        end
        mem_req = 1'b0;
      end
    end
    if (!seen) chk("mem_timeout", 32'h0, 32'h1);
    if (we) begin
      for (int i = 0; i < n; i++) begin
        a_i = addr + 32'(i);
        ref_m[a_i[9:0]] = wd[8*i +: 8];
        chk("store_ram_byte", 32'(ram_m[a_i[9:0]]), 32'(ref_m[a_i[9:0]]));
      end
    end
  endtask

  initial begin
    logic [31:0] expv, a;
    int          mdone_at, idone_at, kind;
    rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    if_addr = '0; mem_addr = '0; mem_len = '0; mem_wdata = '0;
    pre_en = 1'b0; pre_a = '0; pre_d = '0;
    exp_if = '0; exp_mem = '0;
    #1 rst = 1'b0;
    #1;
    chk("rst_if_done", 32'(if_done), 32'h0);
    chk("rst_mem_done", 32'(mem_done), 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_ram_a", ram_a, 32'h0);
    chk("rst_ram_wr", 32'(ram_wr), 32'h0);
    chk("rst_ram_dout", 32'(ram_dout), 32'h0);

    for (int i = 0; i < 1024; i++) preset(32'(i), 8'($urandom));
    preset(32'h100, 8'h13);
    preset(32'h101, 8'h05);
    preset(32'h102, 8'h10);
    preset(32'h103, 8'h00);
    preset(32'h010, 8'h80);

    // Request raised together with reset release: grant on the first edge.
    @(negedge clk);
    rst = 1'b1;
    fetch(32'h100);
    chk("fetch_0x100", if_data, 32'h00100513);

    @(negedge clk);
    mem_xfer(1'b1, 32'h2000, 2'b10, 32'hDEADBEEF);

    // Simultaneous requests: MEM byte load first, then IF.
    @(negedge clk);
    expv = {ref_m[10'h203], ref_m[10'h202], ref_m[10'h201], ref_m[10'h200]};
    idle_chk();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h10; mem_len = 2'b00; mem_wdata = '0;
    if_req = 1'b1; if_addr = 32'h200;
    mdone_at = 0; idone_at = 0;
    for (int cyc = 1; cyc <= 20 && idone_at == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 5) chk("arb_if_ram_a", ram_a, 32'h200);
      if (mem_done) begin
        mdone_at = cyc;
        chk("arb_mem_rdata", mem_rdata, 32'h00000080);
        exp_mem = 32'h00000080;
        mem_req = 1'b0;
      end
      if (if_done) begin
        idone_at = cyc;
        chk("arb_if_data", if_data, expv);
        exp_if = expv;
        if_req = 1'b0;
      end
    end
    chk("arb_mem_cycle", mdone_at, 3);
    chk("arb_if_cycle", idone_at, 10);

    @(negedge clk);
    mem_xfer(1'b0, 32'hFFFFFFFF, 2'b01, 32'h0);
    chk("wrap_half", mem_rdata, {16'h0, ref_m[10'h000], ref_m[10'h3FF]});

    // Word store aborted by reset once bytes 0 and 1 are committed.
    @(negedge clk);
    idle_chk();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h300; mem_len = 2'b10;
    mem_wdata = 32'h11223344;
    repeat (3) @(negedge clk);
    chk("abort_writing", 32'(ram_wr), 32'h1);
    rst = 1'b0;
    mem_req = 1'b0;
    #1;
    chk("abort_ram_wr", 32'(ram_wr), 32'h0);
    chk("abort_ram_a", ram_a, 32'h0);
    chk("abort_ram_dout", 32'(ram_dout), 32'h0);
    chk("abort_mem_rdata", mem_rdata, 32'h0);
    chk("abort_if_data", if_data, 32'h0);
    exp_if = '0; exp_mem = '0;
    ref_m[10'h300] = 8'h44;
    ref_m[10'h301] = 8'h33;
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done_rst", 32'(mem_done), 32'h0);
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_idle_wr", 32'(ram_wr), 32'h0);
      chk("abort_idle_a", ram_a, 32'h0);
      chk("abort_no_done", 32'(mem_done), 32'h0);
    end
    for (int i = 0; i < 4; i++)
      chk("abort_ram_byte", 32'(ram_m[10'h300 + 10'(i)]), 32'(ref_m[10'h300 + 10'(i)]));

    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 2);
      a = ($urandom_range(0, 1) == 1) ? 32'($urandom) : (32'hFFFFFFFC + 32'($urandom_range(0, 7)));
      repeat ($urandom_range(1, 3)) @(negedge clk);
      case (kind)
        0:       fetch(a);
        1:       mem_xfer(1'b0, a, 2'($urandom_range(0, 3)), 32'($urandom));
        default: mem_xfer(1'b1, a, 2'($urandom_range(0, 3)), 32'($urandom));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, expected $finish");
    $fatal(1);
  end

endmodule
